// File: rtl/rmii_tx_framer.sv
// RMII 100 Mb/s transmit framer: preamble/SFD, zero pad to minimum length, inter-frame gap.
// Define ETH_TX_FCS_EN to append a CRC-32 FCS; otherwise upstream supplies the FCS bytes.
module rmii_tx_framer #(
    parameter int IFG_BYTES       = 12,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] S_TDATA,
    input  logic       S_TVALID,
    input  logic       S_TLAST,
    output logic       S_TREADY,
    output logic       ETH_TXEN,
    output logic [1:0] ETH_TXD,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       TX_UNDERRUN
);

`ifdef ETH_TX_FCS_EN
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;
`else
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, IFG} state_t;
`endif

    localparam logic [10:0] MIN_B    = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);

    state_t      state_q, state_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic [10:0] bcnt_q, bcnt_d;
    logic        last_q, last_d;
    logic [7:0]  data_q, data_d;
    logic        txen_q, txen_d;
    logic [1:0]  txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        urun_q, urun_d;
    logic [10:0] bcntInc;
    logic        accept;
    logic        underrun;

    assign S_TREADY    = ((state_q == SFD) || (state_q == DATA)) && (dcnt_q == 2'd3) && !last_q;
    assign accept      = S_TREADY && S_TVALID;
    assign underrun    = S_TREADY && !S_TVALID;
    assign bcntInc     = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;
    assign ETH_TXEN    = txen_q;
    assign ETH_TXD     = txd_q;
    assign TX_BUSY     = busy_q;
    assign TX_DONE     = done_q;
    assign TX_UNDERRUN = urun_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            dcnt_q  <= 2'd0;
            bcnt_q  <= 11'd0;
            last_q  <= 1'b0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            bcnt_q  <= bcnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    // dcnt/bcnt describe the dibit on the wire; bcnt is reused as the byte index of each phase
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q + 2'd1;
        bcnt_d  = bcnt_q;
        last_d  = last_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                dcnt_d = 2'd0;
                bcnt_d = 11'd0;
                last_d = 1'b0;
                if (S_TVALID) state_d = PRE;
            end
            PRE: begin
                if (dcnt_q == 2'd3) begin
                    bcnt_d = bcntInc;
                    if (bcnt_q == 11'd6) begin
                        state_d = SFD;
                        bcnt_d  = 11'd0;
                    end
                end
            end
            SFD, DATA: begin
                if (underrun) begin
                    state_d = IFG;
                    dcnt_d  = 2'd0;
                    bcnt_d  = 11'd0;
                end else if (accept) begin
                    state_d = DATA;
                    bcnt_d  = bcntInc;
                    data_d  = S_TDATA;
                    last_d  = S_TLAST;
                end else if ((state_q == DATA) && (dcnt_q == 2'd3) && last_q) begin
                    if (bcnt_q < MIN_B) begin
                        state_d = PAD;
                    end else begin
`ifdef ETH_TX_FCS_EN
                        state_d = FCS;
`else
                        state_d = IFG;
`endif
                        bcnt_d  = 11'd0;
                    end
                end
            end
            PAD: begin
                if (dcnt_q == 2'd3) begin
                    bcnt_d = bcntInc;
                    if (bcntInc >= MIN_B) begin
`ifdef ETH_TX_FCS_EN
                        state_d = FCS;
`else
                        state_d = IFG;
`endif
                        bcnt_d  = 11'd0;
                    end
                end
            end
`ifdef ETH_TX_FCS_EN
            FCS: begin
                if (dcnt_q == 2'd3) begin
                    bcnt_d = bcntInc;
                    if (bcnt_q == 11'd3) begin
                        state_d = IFG;
                        bcnt_d  = 11'd0;
                    end
                end
            end
`endif
            IFG: begin
                if (dcnt_q == 2'd3) begin
                    bcnt_d = bcntInc;
                    if (bcnt_q == IFG_LAST) begin
                        state_d = IDLE;
                        bcnt_d  = 11'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crcStep(input logic [31:0] c, input logic b);
        crcStep = (c[0] ^ b) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    endfunction

    // CRC follows the dibits actually sent during DATA/PAD; it is frozen while the FCS goes out
    always_comb begin
        crc_d = crc_q;
        if (state_d == SFD) begin
            crc_d = 32'hFFFFFFFF;
        end else if ((state_d == DATA) || (state_d == PAD)) begin
            crc_d = crcStep(crcStep(crc_q, txd_d[0]), txd_d[1]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) crc_q <= 32'hFFFFFFFF;
        else        crc_q <= crc_d;
    end
`endif

    always_comb begin
        txen_d = 1'b1;
        txd_d  = 2'b01;
        busy_d = (state_d != IDLE);
        done_d = (state_d == IFG) && (state_q != IFG) && !underrun;
        urun_d = underrun;
        case (state_d)
            IDLE, IFG: begin
                txen_d = 1'b0;
                txd_d  = 2'b00;
            end
            PRE:  txd_d = 2'b01;
            SFD:  txd_d = (dcnt_d == 2'd3) ? 2'b11 : 2'b01;
            DATA: txd_d = data_d[{dcnt_d, 1'b0} +: 2];
            PAD:  txd_d = 2'b00;
`ifdef ETH_TX_FCS_EN
            FCS:  txd_d = ~crc_q[{bcnt_d[1:0], dcnt_d, 1'b0} +: 2];
`endif
            default: begin
                txen_d = 1'b0;
                txd_d  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            txen_q <= 1'b0;
            txd_q  <= 2'b00;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            urun_q <= 1'b0;
        end else begin
            txen_q <= txen_d;
            txd_q  <= txd_d;
            busy_q <= busy_d;
            done_q <= done_d;
            urun_q <= urun_d;
        end
    end

endmodule

// File: tb/tb_rmii_tx_framer.sv
// Bench for rmii_tx_framer: random payloads driven through valid/ready, wire dibits compared
// against a byte-level frame model (preamble, SFD, pad, software CRC-32 when ETH_TX_FCS_EN is set).
module tb_rmii_tx_framer;

    localparam int IFG_BYTES       = 12;
    localparam int MIN_FRAME_BYTES = 60;
`ifdef ETH_TX_FCS_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] S_TDATA = 8'd0;
    logic       S_TVALID = 1'b0;
    logic       S_TLAST = 1'b0;
    logic       S_TREADY;
    logic       ETH_TXEN;
    logic [1:0] ETH_TXD;
    logic       TX_BUSY;
    logic       TX_DONE;
    logic       TX_UNDERRUN;

    rmii_tx_framer #(
        .IFG_BYTES(IFG_BYTES),
        .MIN_FRAME_BYTES(MIN_FRAME_BYTES)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .S_TDATA(S_TDATA),
        .S_TVALID(S_TVALID),
        .S_TLAST(S_TLAST),
        .S_TREADY(S_TREADY),
        .ETH_TXEN(ETH_TXEN),
        .ETH_TXD(ETH_TXD),
        .TX_BUSY(TX_BUSY),
        .TX_DONE(TX_DONE),
        .TX_UNDERRUN(TX_UNDERRUN)
    );

    always #10 CLK = ~CLK;

    int         assertCount = 0;
    int         failCount = 0;
    logic [7:0] payload[$];
    bit         lastQ[$];
    logic [7:0] fb[$];
    logic [1:0] expQ[$];
    logic [1:0] capQ[$];
    int         riseQ[$];
    int         fallQ[$];
    int         cycle = 0;
    int         doneCnt = 0;
    int         urunCnt = 0;
    int         readyCnt = 0;
    int         ifgCnt = 0;
    logic       prevTxen = 1'b0;
    int         n1, n2, gap;

    always @(posedge CLK) cycle++;

    always @(negedge CLK) begin
        if (ETH_TXEN === 1'b1) capQ.push_back(ETH_TXD);
        if (ETH_TXEN === 1'b1 && !prevTxen) riseQ.push_back(cycle);
        if (ETH_TXEN !== 1'b1 && prevTxen) fallQ.push_back(cycle);
        prevTxen = (ETH_TXEN === 1'b1);
        if (TX_DONE === 1'b1) doneCnt++;
        if (TX_UNDERRUN === 1'b1) urunCnt++;
        if (S_TREADY === 1'b1) readyCnt++;
        if (TX_BUSY === 1'b1 && ETH_TXEN === 1'b0) ifgCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] crcOfFb();
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (fb[k]) begin
            c = c ^ {24'd0, fb[k]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic pushByte(input logic [7:0] b);
        for (int j = 0; j < 4; j++) expQ.push_back(2'((b >> (2 * j)) & 8'h03));
    endtask

    // Expected wire image of one frame built from payload[start +: n]
    task automatic modelFrame(input int start, input int n, input bit complete);
        logic [31:0] fcs;
        for (int k = 0; k < 7; k++) pushByte(8'h55);
        pushByte(8'hD5);
        fb.delete();
        for (int k = 0; k < n; k++) fb.push_back(payload[start + k]);
        if (complete) while (fb.size() < MIN_FRAME_BYTES) fb.push_back(8'h00);
        foreach (fb[k]) pushByte(fb[k]);
        if (complete && FCS_ON) begin
            fcs = ~crcOfFb();
            for (int k = 0; k < 4; k++) pushByte(fcs[8 * k +: 8]);
        end
    endtask

    task automatic addPayload(input int n, input bit useConst, input logic [7:0] c);
        for (int k = 0; k < n; k++) begin
            payload.push_back(useConst ? c : 8'($urandom));
            lastQ.push_back(k == n - 1);
        end
    endtask

    task automatic clearScore();
        payload.delete();
        lastQ.delete();
        expQ.delete();
        capQ.delete();
        riseQ.delete();
        fallQ.delete();
        doneCnt = 0;
        urunCnt = 0;
        readyCnt = 0;
        ifgCnt = 0;
    endtask

    // Offer payload bytes until target have been accepted; keepValid leaves the next byte offered
    task automatic applyStimulus(input int target, input bit keepValid);
        int i = 0;
        int budget = 0;
        S_TDATA  = payload[0];
        S_TLAST  = lastQ[0];
        S_TVALID = 1'b1;
        while (i < target && budget < 4000) begin
            @(negedge CLK);
            budget++;
            if (S_TREADY === 1'b1) begin
                @(posedge CLK);
                #1;
                i++;
                if (i < target) begin
                    S_TDATA = payload[i];
                    S_TLAST = lastQ[i];
                end
            end
        end
        if (!keepValid) begin
            S_TVALID = 1'b0;
            S_TLAST  = 1'b0;
            S_TDATA  = 8'd0;
        end
        checkOutput("driver bytes accepted", i, target);
    endtask

    task automatic waitIdle(input string tag);
        int budget = 0;
        while (TX_BUSY !== 1'b0 && budget < 3000) begin
            @(negedge CLK);
            budget++;
        end
        checkOutput({tag, " idle reached"}, {31'd0, TX_BUSY}, 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic checkFrame(input string tag, input int nFrames, input int expReady,
                              input int expDone, input int expUrun, input int expIfg);
        int mism = 0;
        checkOutput({tag, " txen cycles"}, capQ.size(), expQ.size());
        for (int k = 0; k < expQ.size(); k++)
            if (k >= capQ.size() || capQ[k] !== expQ[k]) mism++;
        checkOutput({tag, " dibit errors"}, mism, 0);
        checkOutput({tag, " txen bursts"}, riseQ.size(), nFrames);
        checkOutput({tag, " tready cycles"}, readyCnt, expReady);
        checkOutput({tag, " done pulses"}, doneCnt, expDone);
        checkOutput({tag, " underrun pulses"}, urunCnt, expUrun);
        checkOutput({tag, " ifg cycles"}, ifgCnt, expIfg);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        checkOutput("reset txen", {31'd0, ETH_TXEN}, 32'd0);
        checkOutput("reset txd", {30'd0, ETH_TXD}, 32'd0);
        checkOutput("reset tready", {31'd0, S_TREADY}, 32'd0);
        checkOutput("reset busy", {31'd0, TX_BUSY}, 32'd0);
        checkOutput("reset done", {31'd0, TX_DONE}, 32'd0);
        checkOutput("reset underrun", {31'd0, TX_UNDERRUN}, 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        clearScore();
        addPayload(1, 1'b1, 8'hAB);
        modelFrame(0, 1, 1'b1);
        applyStimulus(1, 1'b0);
        waitIdle("single");
        checkFrame("single", 1, 1, 1, 0, IFG_BYTES * 4);
        checkOutput("single txen length", capQ.size(), FCS_ON ? 288 : 272);

        clearScore();
        addPayload(64, 1'b0, 8'h00);
        modelFrame(0, 64, 1'b1);
        applyStimulus(64, 1'b0);
        waitIdle("len64");
        checkFrame("len64", 1, 64, 1, 0, IFG_BYTES * 4);
        checkOutput("len64 txen length", capQ.size(), FCS_ON ? 304 : 288);

        for (int r = 0; r < 4; r++) begin
            clearScore();
            n1 = $urandom_range(1, 100);
            addPayload(n1, 1'b0, 8'h00);
            modelFrame(0, n1, 1'b1);
            applyStimulus(n1, 1'b0);
            waitIdle("random");
            checkFrame("random", 1, n1, 1, 0, IFG_BYTES * 4);
        end

        clearScore();
        addPayload(20, 1'b0, 8'h00);
        modelFrame(0, 10, 1'b0);
        applyStimulus(10, 1'b0);
        waitIdle("underrun");
        checkFrame("underrun", 1, 11, 0, 1, IFG_BYTES * 4);
        checkOutput("underrun txen length", capQ.size(), 72);

        clearScore();
        n1 = $urandom_range(1, 80);
        n2 = $urandom_range(1, 80);
        addPayload(n1, 1'b0, 8'h00);
        addPayload(n2, 1'b0, 8'h00);
        modelFrame(0, n1, 1'b1);
        modelFrame(n1, n2, 1'b1);
        applyStimulus(n1 + n2, 1'b0);
        waitIdle("b2b");
        checkFrame("b2b", 2, n1 + n2, 2, 0, 2 * IFG_BYTES * 4);
        gap = (riseQ.size() >= 2 && fallQ.size() >= 1) ? riseQ[1] - fallQ[0] : -1;
        checkOutput("b2b fall-to-rise gap", gap, 49);

        clearScore();
        addPayload(30, 1'b0, 8'h00);
        applyStimulus(5, 1'b1);
        @(negedge CLK);
        checkOutput("pre-reset txen", {31'd0, ETH_TXEN}, 32'd1);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("async reset txen", {31'd0, ETH_TXEN}, 32'd0);
        checkOutput("async reset txd", {30'd0, ETH_TXD}, 32'd0);
        checkOutput("async reset tready", {31'd0, S_TREADY}, 32'd0);
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("async reset busy", {31'd0, TX_BUSY}, 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        clearScore();
        n1 = $urandom_range(40, 70);
        addPayload(n1, 1'b0, 8'h00);
        modelFrame(0, n1, 1'b1);
        applyStimulus(n1, 1'b0);
        waitIdle("post-reset");
        checkFrame("post-reset", 1, n1, 1, 0, IFG_BYTES * 4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
